// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with load/branch hazard detection, stall FSM and saturating stall counter
module if_id_stage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] InstructionIn,
  input  logic [31:0] PCPlus4In,
  input  logic        IFFlush,
  input  logic        IDEXMemRead,
  input  logic        IDEXRegWrite,
  input  logic [4:0]  IDEXWriteReg,
  input  logic        EXMEMMemRead,
  input  logic [4:0]  EXMEMWriteReg,
  output logic [31:0] InstructionOut,
  output logic [31:0] PCPlus4Out,
  output logic        ValidOut,
  output logic        Stall,
  output logic        PCWrite,
  output logic        IDEXFlush,
  output logic [1:0]  State,
  output logic [15:0] StallCount
);
  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, FLUSHED = 2'd2} stateT;
  stateT state;
  logic [5:0] op;
  logic [4:0] rs, rt;
  logic usesRs, usesRt, isBranch, matchEx, matchMem;
  assign op = InstructionOut[31:26];
  assign rs = InstructionOut[25:21];
  assign rt = InstructionOut[20:16];
  assign usesRs = !(op == 6'd2 || op == 6'd3) && InstructionOut != 32'd0;
  assign usesRt = op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
  assign isBranch = op == 6'h04 || op == 6'h05;
  assign matchEx = ValidOut && IDEXWriteReg != 5'd0 &&
                   ((usesRs && rs == IDEXWriteReg) || (usesRt && rt == IDEXWriteReg));
  assign matchMem = ValidOut && EXMEMWriteReg != 5'd0 &&
                    ((usesRs && rs == EXMEMWriteReg) || (usesRt && rt == EXMEMWriteReg));
  assign Stall = (IDEXMemRead && matchEx) ||
                 (isBranch && IDEXRegWrite && !IDEXMemRead && matchEx) ||
                 (isBranch && EXMEMMemRead && matchMem);
  assign PCWrite = !Stall;
  assign IDEXFlush = Stall;
  assign State = state;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      InstructionOut <= 32'd0;
      PCPlus4Out <= 32'd0;
      ValidOut <= 1'b0;
      state <= RUN;
      StallCount <= 16'd0;
    end else begin
      state <= Stall ? HOLD : IFFlush ? FLUSHED : RUN;
      if (Stall && StallCount != 16'hFFFF) StallCount <= StallCount + 16'd1;
      if (!Stall) begin
        InstructionOut <= IFFlush ? 32'd0 : InstructionIn;
        PCPlus4Out <= PCPlus4In;
        ValidOut <= !IFFlush;
      end
    end
  end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: table-driven, random and long-run checks of if_id_stage against a reference model
module tb_if_id_stage;
  logic        Clk = 1'b0;
  logic        Reset, IFFlush, IDEXMemRead, IDEXRegWrite, EXMEMMemRead;
  logic [31:0] InstructionIn, PCPlus4In;
  logic [4:0]  IDEXWriteReg, EXMEMWriteReg;
  logic [31:0] InstructionOut, PCPlus4Out;
  logic        ValidOut, Stall, PCWrite, IDEXFlush;
  logic [1:0]  State;
  logic [15:0] StallCount;

  if_id_stage dut (
    .Clk(Clk), .Reset(Reset), .InstructionIn(InstructionIn), .PCPlus4In(PCPlus4In),
    .IFFlush(IFFlush), .IDEXMemRead(IDEXMemRead), .IDEXRegWrite(IDEXRegWrite),
    .IDEXWriteReg(IDEXWriteReg), .EXMEMMemRead(EXMEMMemRead), .EXMEMWriteReg(EXMEMWriteReg),
    .InstructionOut(InstructionOut), .PCPlus4Out(PCPlus4Out), .ValidOut(ValidOut),
    .Stall(Stall), .PCWrite(PCWrite), .IDEXFlush(IDEXFlush), .State(State),
    .StallCount(StallCount)
  );

  always #5 Clk = ~Clk;

  localparam logic [31:0] ADD = 32'h010A4820;
  localparam logic [31:0] ORI = 32'h018D5825;
  localparam logic [31:0] BEQ = 32'h11000004;
  localparam logic [31:0] LW  = 32'h8C080004;
  localparam logic [31:0] SW  = 32'hAD280000;
  localparam logic [31:0] J   = 32'h09000000;
  localparam logic [31:0] JAL = 32'h0D000000;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] mInstr, mPc;
  logic mValid;
  int mState, mCount;
  logic lastStall;

  typedef struct {
    logic rst, flush;
    logic [31:0] instr, pc;
    logic idMr, idRw;
    logic [4:0] idWr;
    logic exMr;
    logic [4:0] exWr;
    logic eStall;
    logic [1:0] eState;
    logic eValid;
    logic [31:0] eInstr;
  } vecT;
  vecT tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit hits(input int r, input int rs, input int rt, input bit ur, input bit ut);
    return mValid && r != 0 && ((ur && rs == r) || (ut && rt == r));
  endfunction

  function automatic bit refStall();
    int op, rs, rt;
    bit ur, ut, br;
    op = int'(mInstr[31:26]);
    rs = int'(mInstr[25:21]);
    rt = int'(mInstr[20:16]);
    ur = !(op == 2 || op == 3) && mInstr != 0;
    ut = op == 0 || op == 4 || op == 5 || op == 40 || op == 41 || op == 43;
    br = op == 4 || op == 5;
    return (IDEXMemRead && hits(int'(IDEXWriteReg), rs, rt, ur, ut)) ||
           (br && IDEXRegWrite && !IDEXMemRead && hits(int'(IDEXWriteReg), rs, rt, ur, ut)) ||
           (br && EXMEMMemRead && hits(int'(EXMEMWriteReg), rs, rt, ur, ut));
  endfunction

  task automatic tick();
    bit s;
    #1;
    s = refStall();
    lastStall = Stall;
    chk("stall", Stall, s);
    chk("pcwrite", PCWrite, !s);
    chk("idexflush", IDEXFlush, s);
    @(posedge Clk);
    if (Reset) begin
      mInstr = 0; mPc = 0; mValid = 0; mState = 0; mCount = 0;
    end else begin
      mState = s ? 1 : (IFFlush ? 2 : 0);
      if (s && mCount < 65535) mCount++;
      if (!s) begin
        mInstr = IFFlush ? 32'd0 : InstructionIn;
        mPc = PCPlus4In;
        mValid = !IFFlush;
      end
    end
    #1;
    chk("instr_out", InstructionOut, mInstr);
    chk("pc_out", PCPlus4Out, mPc);
    chk("valid_out", ValidOut, mValid);
    chk("state", State, mState);
    chk("stall_count", StallCount, mCount);
  endtask

  task automatic drive(input logic rst, input logic fl, input logic [31:0] ins, input logic [31:0] pc,
                       input logic imr, input logic irw, input logic [4:0] iwr,
                       input logic emr, input logic [4:0] ewr);
    Reset = rst; IFFlush = fl; InstructionIn = ins; PCPlus4In = pc;
    IDEXMemRead = imr; IDEXRegWrite = irw; IDEXWriteReg = iwr;
    EXMEMMemRead = emr; EXMEMWriteReg = ewr;
  endtask

  initial begin
    tbl[0]  = '{0, 0, ADD, 32'h104, 0, 0, 5'd0, 0, 5'd0, 0, 2'd0, 1, ADD};
    tbl[1]  = '{0, 0, ORI, 32'h108, 1, 0, 5'd8, 0, 5'd0, 1, 2'd1, 1, ADD};
    tbl[2]  = '{0, 0, ORI, 32'h108, 0, 0, 5'd0, 0, 5'd0, 0, 2'd0, 1, ORI};
    tbl[3]  = '{0, 0, BEQ, 32'h10C, 0, 0, 5'd0, 0, 5'd0, 0, 2'd0, 1, BEQ};
    tbl[4]  = '{0, 0, ADD, 32'h110, 1, 1, 5'd8, 0, 5'd0, 1, 2'd1, 1, BEQ};
    tbl[5]  = '{0, 0, ADD, 32'h110, 0, 0, 5'd0, 1, 5'd8, 1, 2'd1, 1, BEQ};
    tbl[6]  = '{0, 0, ADD, 32'h110, 0, 0, 5'd0, 0, 5'd0, 0, 2'd0, 1, ADD};
    tbl[7]  = '{0, 0, BEQ, 32'h114, 0, 0, 5'd0, 0, 5'd0, 0, 2'd0, 1, BEQ};
    tbl[8]  = '{0, 0, ORI, 32'h118, 0, 1, 5'd8, 0, 5'd0, 1, 2'd1, 1, BEQ};
    tbl[9]  = '{0, 0, ORI, 32'h118, 0, 0, 5'd0, 0, 5'd8, 0, 2'd0, 1, ORI};
    tbl[10] = '{0, 1, LW,  32'h11C, 0, 0, 5'd0, 0, 5'd0, 0, 2'd2, 0, 32'd0};
    tbl[11] = '{0, 0, ADD, 32'h120, 1, 0, 5'd8, 0, 5'd0, 0, 2'd0, 1, ADD};
    tbl[12] = '{0, 1, LW,  32'h124, 1, 0, 5'd8, 0, 5'd0, 1, 2'd1, 1, ADD};
    tbl[13] = '{0, 0, J,   32'h128, 1, 0, 5'd0, 0, 5'd0, 0, 2'd0, 1, J};
    tbl[14] = '{0, 0, JAL, 32'h12C, 1, 0, 5'd8, 0, 5'd0, 0, 2'd0, 1, JAL};
    tbl[15] = '{0, 0, LW,  32'h130, 1, 0, 5'd8, 1, 5'd8, 0, 2'd0, 1, LW};
    tbl[16] = '{0, 0, SW,  32'h134, 1, 0, 5'd8, 0, 5'd0, 0, 2'd0, 1, SW};
    tbl[17] = '{0, 0, ADD, 32'h138, 1, 0, 5'd8, 0, 5'd0, 1, 2'd1, 1, SW};
    tbl[18] = '{1, 0, ADD, 32'h13C, 1, 0, 5'd8, 0, 5'd0, 1, 2'd0, 0, 32'd0};
    tbl[19] = '{0, 0, ADD, 32'h140, 1, 0, 5'd8, 0, 5'd0, 0, 2'd0, 1, ADD};

    drive(1, 0, 32'd0, 32'd0, 0, 0, 5'd0, 0, 5'd0);
    repeat (2) @(posedge Clk);
    #1;
    mInstr = 0; mPc = 0; mValid = 0; mState = 0; mCount = 0;
    chk("rst_instr", InstructionOut, 32'd0);
    chk("rst_pc", PCPlus4Out, 32'd0);
    chk("rst_valid", ValidOut, 1'b0);
    chk("rst_state", State, 2'd0);
    chk("rst_count", StallCount, 16'd0);
    chk("rst_stall", Stall, 1'b0);
    chk("rst_pcwrite", PCWrite, 1'b1);
    chk("rst_idexflush", IDEXFlush, 1'b0);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].instr, tbl[i].pc, tbl[i].idMr, tbl[i].idRw,
            tbl[i].idWr, tbl[i].exMr, tbl[i].exWr);
      tick();
      chk($sformatf("tbl%0d_stall", i), lastStall, tbl[i].eStall);
      chk($sformatf("tbl%0d_state", i), State, tbl[i].eState);
      chk($sformatf("tbl%0d_valid", i), ValidOut, tbl[i].eValid);
      chk($sformatf("tbl%0d_instr", i), InstructionOut, tbl[i].eInstr);
      if (i == 1) chk("loaduse_count", StallCount, 16'd1);
    end

    for (int i = 0; i < 600; i++) begin
      logic [5:0] ops [10];
      logic [31:0] ins;
      ops = '{6'h00, 6'h04, 6'h05, 6'h23, 6'h28, 6'h29, 6'h2B, 6'h02, 6'h03, 6'h08};
      ins = {ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             16'($urandom)};
      if ($urandom_range(0, 9) == 0) ins = 32'd0;
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0, ins, $urandom,
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), 5'($urandom_range(0, 3)));
      tick();
    end

    drive(1, 0, 32'd0, 32'd0, 0, 0, 5'd0, 0, 5'd0);
    tick();
    drive(0, 0, ADD, 32'h200, 0, 0, 5'd0, 0, 5'd0);
    tick();
    drive(0, 1, LW, 32'h204, 1, 0, 5'd8, 0, 5'd0);
    repeat (65540) tick();
    chk("sat_count", StallCount, 16'hFFFF);
    chk("sat_hold", InstructionOut, ADD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The module SHALL have the following ports, clock and reset first:
- Clk  in  1  single clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset, sampled on the rising edge of Clk.
- InstructionIn  in  32  fetched instruction.
- PCPlus4In  in  32  fetch PC + 4.
- IFFlush  in  1  branch taken or jump resolved in ID; squash the fetched instruction.
- IDEXMemRead  in  1  the instruction in EX is a load.
- IDEXRegWrite  in  1  the instruction in EX writes a register.
- IDEXWriteReg  in  5  destination register of the instruction in EX.
- EXMEMMemRead  in  1  the instruction in MEM is a load.
- EXMEMWriteReg  in  5  destination register of the instruction in MEM.
- InstructionOut  out  32  registered instruction presented to ID.
- PCPlus4Out  out  32  registered PC + 4 presented to ID.
- ValidOut  out  1  InstructionOut is a real instruction, not a bubble.
- Stall  out  1  combinational hazard stall.
- PCWrite  out  1  combinational; equals NOT Stall.
- IDEXFlush  out  1  combinational; equals Stall; drives the Flush input of the ID/EX register.
- State  out  2  FSM state.
- StallCount  out  16  saturating count of stall cycles.

Function
REQ-002 Decode fields from InstructionOut: op = [31:26], rs = [25:21], rt = [20:16].
REQ-003 usesRs SHALL be 1 unless op is 2 or 3, or InstructionOut is 0x00000000.
REQ-004 usesRt SHALL be 1 for op 0x00, 0x04, 0x05, 0x28, 0x29 and 0x2B, and 0 otherwise.
REQ-005 isBranch SHALL be 1 for op 0x04 or 0x05.
REQ-006 match(r) SHALL be 1 when ValidOut=1, r != 0, and either (usesRs and rs == r) or (usesRt and rt == r).
REQ-007 Three hazard terms SHALL be computed:
- H1 = IDEXMemRead and match(IDEXWriteReg).
- H2 = isBranch and IDEXRegWrite and NOT IDEXMemRead and match(IDEXWriteReg).
- H3 = isBranch and EXMEMMemRead and match(EXMEMWriteReg).
REQ-008 Stall SHALL be the OR of H1, H2 and H3; it is purely combinational, with no register delay.
REQ-009 When Stall=1, InstructionOut, PCPlus4Out and ValidOut SHALL hold their values, and IFFlush SHALL be ignored.
REQ-010 When Stall=0 and IFFlush=1, the block SHALL load InstructionOut=0x00000000, PCPlus4Out=PCPlus4In and ValidOut=0.
REQ-011 When Stall=0 and IFFlush=0, the block SHALL load InstructionIn, PCPlus4In and ValidOut=1.
REQ-012 Priority SHALL be Reset > Stall > IFFlush > normal load.
REQ-013 A branch depending on a load in EX SHALL stall exactly 2 cycles (H1, then H3); a branch depending on an ALU result in EX SHALL stall exactly 1 cycle.
REQ-014 The FSM SHALL have states RUN=0, HOLD=1 and FLUSHED=2, with transitions evaluated every cycle:
- Any state with Stall=1 -> HOLD.
- Otherwise, with IFFlush=1 -> FLUSHED.
- Otherwise -> RUN.
- Encoding 3 is illegal and SHALL go to RUN.
REQ-015 StallCount SHALL increment by 1 on each cycle with Stall=1 and saturate at 0xFFFF with no wrap.

Reset
REQ-016 On Reset=1 at a rising edge, the block SHALL set InstructionOut=0, PCPlus4Out=0, ValidOut=0, State=RUN and StallCount=0, regardless of Stall and IFFlush.
REQ-017 Stall, PCWrite and IDEXFlush SHALL be 0, 1 and 0 respectively whenever ValidOut=0, including directly after reset.
REQ-018 Reset asserted during a HOLD sequence SHALL abort it; the next non-reset cycle SHALL load InstructionIn normally.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Load-use: IDEX load to $8 (IDEXMemRead=1, IDEXWriteReg=8), InstructionOut add $9,$8,$10 -> Stall=1, PCWrite=0, IDEXFlush=1 for 1 cycle; outputs held; State=HOLD; StallCount=1.
- Branch after load: beq $8,$0 in ID with a load to $8 in EX -> Stall for 2 consecutive cycles (H1, then H3); branch released on the 3rd cycle.
- Flush: IFFlush=1 with no hazard, InstructionIn=0x8C080004 -> next InstructionOut=0, ValidOut=0, State=FLUSHED; following cycle loads normally, State=RUN.
- Stall plus flush: Stall=1 and IFFlush=1 together -> hold wins; ValidOut stays 1; State=HOLD.
- $0 and non-users: load to $0 in EX, or j/jal in ID with a matching register field -> Stall=0.
- Reset mid-stall, then saturation: Reset during HOLD -> all outputs 0 next edge; force 65540 stall cycles -> StallCount=0xFFFF.
